// File: rtl/fir_interp_coeff_loader.sv
// rtl/fir_interp_coeff_loader.sv - coefficient load, commit and settle sequencer for the polyphase FIR interpolator
// Optional trailing checksum beat enabled by defining COEFF_LOADER_CHECKSUM_EN.
module fir_interp_coeff_loader #(
    parameter int ORD        = 255,
    parameter int M          = 8,
    parameter int D          = 52,
    parameter int COEFF_SIZE = 16,
    localparam int NCOEF      = (ORD + 1) / 2,
    localparam int ADDR_W     = $clog2(NCOEF),
    localparam int SETTLE_CYC = (ORD + 3) * D,
    localparam int BEAT_W     = $clog2(NCOEF + 1),
    localparam int SETTLE_W   = $clog2(SETTLE_CYC + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [COEFF_SIZE-1:0] s_data,
    output logic                  c_we,
    output logic [ADDR_W-1:0]     c_addr,
    output logic [COEFF_SIZE-1:0] c_in,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  done,
    output logic                  err
);

    if (M < 1 || (ORD % 2) == 0) begin : g_cfg_check
        $error("fir_interp_coeff_loader: M must be >= 1 and ORD must be odd");
    end

    localparam logic [BEAT_W-1:0]   BEAT_TAPS   = BEAT_W'(NCOEF);
    localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(NCOEF - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_TERM = SETTLE_W'(SETTLE_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t                state_q,     state_d;
    logic [BEAT_W-1:0]     beat_q,      beat_d;
    logic [SETTLE_W-1:0]   settle_q,    settle_d;
    logic [ADDR_W-1:0]     c_addr_q,    c_addr_d;
    logic [COEFF_SIZE-1:0] c_in_q,      c_in_d;
    logic                  s_ready_q,   s_ready_d;
    logic                  c_we_q,      c_we_d;
    logic                  busy_q,      busy_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q,      done_d;
    logic                  accept;
`ifdef COEFF_LOADER_CHECKSUM_EN
    logic [COEFF_SIZE-1:0] sum_q,       sum_d;
    logic                  err_q,       err_d;
`endif

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        settle_d = settle_q;
        c_addr_d = c_addr_q;
        c_in_d   = c_in_q;
        done_d   = 1'b0;
        accept   = s_valid && s_ready_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (beat_q < BEAT_TAPS) begin
                        c_addr_d = beat_q[ADDR_W-1:0];
                        c_in_d   = s_data;
                        beat_d   = beat_q + 1'b1;
`ifdef COEFF_LOADER_CHECKSUM_EN
                        sum_d    = sum_q + s_data;
`else
                        if (beat_q == BEAT_LAST) begin
                            state_d = S_COMMIT;
                        end
`endif
                    end
`ifdef COEFF_LOADER_CHECKSUM_EN
                    // Checksum beat: never written to the filter, only compared.
                    else if (s_data == sum_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_COMMIT: begin
                state_d  = S_SETTLE;
                settle_d = '0;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end
                if (settle_q != SETTLE_TERM) begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: ;
        endcase

        // start takes priority over settle completion; ignored while LOAD/COMMIT own the filter port.
        if (start && (state_q == S_IDLE || state_q == S_SETTLE || state_q == S_RUN)) begin
            state_d  = S_LOAD;
            beat_d   = '0;
            c_addr_d = '0;
            c_in_d   = '0;
            done_d   = 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_d    = '0;
            err_d    = 1'b0;
`endif
        end

        s_ready_d   = (state_d == S_LOAD);
        c_we_d      = (state_d == S_LOAD) || (state_d == S_COMMIT);
        busy_d      = (state_d == S_LOAD) || (state_d == S_COMMIT) || (state_d == S_SETTLE);
        out_valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            settle_q    <= '0;
            c_addr_q    <= '0;
            c_in_q      <= '0;
            s_ready_q   <= 1'b0;
            c_we_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            settle_q    <= settle_d;
            c_addr_q    <= c_addr_d;
            c_in_q      <= c_in_d;
            s_ready_q   <= s_ready_d;
            c_we_q      <= c_we_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign c_we      = c_we_q;
    assign c_addr    = c_addr_q;
    assign c_in      = c_in_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_interp_coeff_loader.sv
// tb/tb_fir_interp_coeff_loader.sv - randomized self-checking bench for fir_interp_coeff_loader
module tb_fir_interp_coeff_loader;
    localparam int ORD        = 255;
    localparam int D          = 52;
    localparam int CS         = 16;
    localparam int NCOEF      = (ORD + 1) / 2;
    localparam int AW         = $clog2(NCOEF);
    localparam int SETTLE_CYC = (ORD + 3) * D;

    logic          clk = 1'b0;
    logic          rst, start, s_valid, s_ready;
    logic [CS-1:0] s_data, c_in;
    logic          c_we, busy, out_valid, done, err;
    logic [AW-1:0] c_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int done_pulses = 0;

    logic [CS-1:0] filt [NCOEF];
    logic [CS-1:0] taps [NCOEF];
    logic [CS-1:0] beats [$];

    always #5 clk = ~clk;

    fir_interp_coeff_loader #(.ORD(ORD), .M(8), .D(D), .COEFF_SIZE(CS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .c_we(c_we), .c_addr(c_addr), .c_in(c_in),
        .busy(busy), .out_valid(out_valid), .done(done), .err(err)
    );

    // Filter coefficient RAM as the interpolator sees it.
    always @(posedge clk) if (c_we) filt[c_addr] <= c_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (done) done_pulses++;
            check("inv_ready_only_in_load", s_ready & ~(c_we & busy), 0);
            check("inv_valid_excludes_busy", out_valid & busy, 0);
            check("inv_done_implies_run", done & ~out_valid, 0);
`ifndef COEFF_LOADER_CHECKSUM_EN
            check("inv_err_tied_low", err, 0);
`endif
        end
    end

    task automatic randomize_taps();
        for (int i = 0; i < NCOEF; i++) taps[i] = CS'($urandom);
    endtask

    task automatic build_beats(input int csum_off);
        logic [CS-1:0] sum;
        sum = '0;
        beats.delete();
        for (int i = 0; i < NCOEF; i++) begin
            beats.push_back(taps[i]);
            sum = sum + taps[i];
        end
`ifdef COEFF_LOADER_CHECKSUM_EN
        beats.push_back(sum + CS'(csum_off));
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Entered and left on a negedge; returns just after the edge that took the last beat.
    task automatic send(input int first, input int last, input int gap_pct);
        int   idx;
        int   budget;
        logic acc;
        idx = first;
        budget = 0;
        while (idx < last && budget < 4000) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? beats[idx] : CS'($urandom);
            acc     = s_valid && s_ready;
            @(negedge clk);
            if (acc) idx++;
            budget++;
        end
        s_valid = 1'b0;
        check("send_beats_accepted", idx, last);
    endtask

    task automatic check_commit(input string tag);
        check({tag, "_commit_addr"}, c_addr, NCOEF - 1);
        check({tag, "_commit_data"}, c_in, taps[NCOEF-1]);
        check({tag, "_commit_we"}, c_we, 1);
        check({tag, "_commit_ready"}, s_ready, 0);
        check({tag, "_commit_busy"}, busy, 1);
        @(negedge clk);
        check({tag, "_settle_we"}, c_we, 0);
        check({tag, "_settle_busy"}, busy, 1);
        check({tag, "_settle_valid"}, out_valid, 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < SETTLE_CYC + 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_settle_cycles"}, n, SETTLE_CYC);
        check({tag, "_run_valid"}, out_valid, 1);
        check({tag, "_run_busy"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_run_valid_hold"}, out_valid, 1);
    endtask

    task automatic check_filt(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NCOEF; i++) if (filt[i] !== taps[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_load_entry(input string tag);
        check({tag, "_we"}, c_we, 1);
        check({tag, "_ready"}, s_ready, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_addr"}, c_addr, 0);
        check({tag, "_data"}, c_in, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_we", c_we, 0);
        check("rst_addr", c_addr, 0);
        check("rst_data", c_in, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < NCOEF; i++) taps[i] = CS'(i + 1);
        build_beats(0);
        pulse_start();
        check_load_entry("t1_load");
        send(0, beats.size(), 0);
        check_commit("t1");
        wait_done("t1");
        check_filt("t1_filter_contents");

        randomize_taps();
        build_beats(0);
        pulse_start();
        check_load_entry("t2_run_to_load");
        send(0, beats.size(), 50);
        check_commit("t2");
        wait_done("t2");
        check_filt("t2_filter_contents");

        randomize_taps();
        build_beats(0);
        pulse_start();
        send(0, 40, 30);
        pulse_start();
        check("t3_start_in_load_busy", busy, 1);
        check("t3_start_in_load_ready", s_ready, 1);
        check("t3_start_in_load_addr", c_addr, 39);
        check("t3_start_in_load_data", c_in, taps[39]);
        send(40, beats.size(), 30);
        check_commit("t3a");
        repeat (100) @(negedge clk);
        pulse_start();
        check_load_entry("t3_settle_restart");
        randomize_taps();
        build_beats(0);
        send(0, beats.size(), 30);
        check_commit("t3b");
        wait_done("t3b");
        check_filt("t3_filter_contents");

        pulse_start();
        randomize_taps();
        build_beats(0);
        send(0, 60, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_we", c_we, 0);
        check("t4_rst_ready", s_ready, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_valid", out_valid, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_idle_busy", busy, 0);
        randomize_taps();
        build_beats(0);
        pulse_start();
        check_load_entry("t4_reload");
        send(0, beats.size(), 20);
        check_commit("t4");
        check_filt("t4_filter_contents");

`ifdef COEFF_LOADER_CHECKSUM_EN
        begin
            int pulses_before;
            for (int i = 0; i < NCOEF; i++) taps[i] = CS'(1);
            build_beats(0);
            pulse_start();
            send(0, beats.size(), 0);
            check("t5_csum_word", beats[NCOEF], 128);
            check_commit("t5");
            wait_done("t5");
            check("t5_err_clear", err, 0);

            build_beats(-1);
            pulse_start();
            send(0, beats.size(), 0);
            check("t6_err_set", err, 1);
            check("t6_idle_busy", busy, 0);
            check("t6_idle_we", c_we, 0);
            check("t6_idle_ready", s_ready, 0);
            check("t6_idle_valid", out_valid, 0);
            pulses_before = done_pulses;
            repeat (200) @(negedge clk);
            check("t6_no_done", done_pulses, pulses_before);
            check("t6_err_sticky", err, 1);
            check("t6_still_invalid", out_valid, 0);
            pulse_start();
            check("t6_start_clears_err", err, 0);
            check("t6_reload_busy", busy, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
